// File: rtl/i8254_pkg.sv
// Shared types and constants for the 8254 bus sequencer: control-word layout,
// read/write access codes and address decode values.
package i8254_pkg;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_t;

    typedef logic [2:0] mode_t;

    typedef struct packed {
        logic [1:0] sc;
        rw_t        rw;
        mode_t      m;
        logic       bcd;
    } ctrl_word_t;

    localparam logic [1:0] ADDR_CTRL   = 2'b11;
    localparam logic [1:0] SC_READBACK = 2'b11;

    // Modes 6 and 7 are aliases of 2 and 3.
    function automatic mode_t fold_mode(input mode_t m);
        return {m[2] & ~m[1], m[1:0]};
    endfunction

endpackage

// File: rtl/i8254_byte_ptr.sv
// Per-counter bus state: configuration, LSB/MSB write and read pointers,
// staging byte, count/status latches and null_count. Status latch exists only with I8254_READBACK_EN.
module i8254_byte_ptr
    import i8254_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        cfg_en,
    input  logic        latch_en,
    input  logic        stat_en,
    input  logic [7:0]  d,
    input  logic [15:0] count,
    input  logic        out_pin,
    input  logic        count_loaded,
    output logic        load,
    output logic [15:0] load_value,
    output logic        cfg_strobe,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic        null_count,
    output logic [7:0]  rd_byte
);

    ctrl_word_t  cw;
    rw_t         rw_reg;
    mode_t       mode_reg;
    logic        bcd_reg;
    logic        wr_msb_reg;
    logic        rd_msb_reg;
    logic [7:0]  stage_reg;
    logic [15:0] latch_reg;
    logic        latch_held_reg;
    logic        load_reg;
    logic [15:0] load_value_reg;
    logic        cfg_strobe_reg;
    logic        null_reg;
    logic        stat_held;
    logic [7:0]  stat_byte;
    logic [7:0]  status_now;
    logic [15:0] src;
    logic [7:0]  cnt_byte;

    assign cw         = d;
    assign status_now = {out_pin, null_reg, rw_reg, mode_reg, bcd_reg};

    always_comb begin
        src = latch_held_reg ? latch_reg : count;
        case (rw_reg)
            RW_MSB:     cnt_byte = src[15:8];
            RW_LSB_MSB: cnt_byte = rd_msb_reg ? src[15:8] : src[7:0];
            default:    cnt_byte = src[7:0];
        endcase
        rd_byte = stat_held ? stat_byte : cnt_byte;
    end

`ifdef I8254_READBACK_EN
    logic       stat_held_reg;
    logic [7:0] stat_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_held_reg <= 1'b0;
            stat_reg      <= 8'h00;
        end else if (cfg_en || (rd_en && stat_held_reg)) begin
            stat_held_reg <= 1'b0;
        end else if (stat_en && !stat_held_reg) begin
            stat_reg      <= status_now;
            stat_held_reg <= 1'b1;
        end
    end

    assign stat_held = stat_held_reg;
    assign stat_byte = stat_reg;
`else
    logic unused_status;
    assign unused_status = &{1'b0, stat_en, status_now};
    assign stat_held     = 1'b0;
    assign stat_byte     = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_reg         <= RW_LSB;
            mode_reg       <= '0;
            bcd_reg        <= 1'b0;
            wr_msb_reg     <= 1'b0;
            rd_msb_reg     <= 1'b0;
            stage_reg      <= 8'h00;
            latch_reg      <= 16'h0000;
            latch_held_reg <= 1'b0;
            load_reg       <= 1'b0;
            load_value_reg <= 16'h0000;
            cfg_strobe_reg <= 1'b0;
            null_reg       <= 1'b0;
        end else begin
            load_reg       <= 1'b0;
            cfg_strobe_reg <= 1'b0;
            if (count_loaded)
                null_reg <= 1'b0;
            if (cfg_en) begin
                rw_reg         <= cw.rw;
                mode_reg       <= fold_mode(cw.m);
                bcd_reg        <= cw.bcd;
                wr_msb_reg     <= 1'b0;
                rd_msb_reg     <= 1'b0;
                latch_held_reg <= 1'b0;
                null_reg       <= 1'b1;
                cfg_strobe_reg <= 1'b1;
            end
            if (latch_en && !latch_held_reg) begin
                latch_reg      <= count;
                latch_held_reg <= 1'b1;
            end
            if (wr_en) begin
                case (rw_reg)
                    RW_MSB: begin
                        load_value_reg <= {d, 8'h00};
                        load_reg       <= 1'b1;
                        null_reg       <= 1'b1;
                    end
                    RW_LSB_MSB: begin
                        if (!wr_msb_reg) begin
                            stage_reg  <= d;
                            wr_msb_reg <= 1'b1;
                        end else begin
                            load_value_reg <= {d, stage_reg};
                            load_reg       <= 1'b1;
                            null_reg       <= 1'b1;
                            wr_msb_reg     <= 1'b0;
                        end
                    end
                    default: begin
                        load_value_reg <= {8'h00, d};
                        load_reg       <= 1'b1;
                        null_reg       <= 1'b1;
                    end
                endcase
            end
            // A pending status byte is consumed first and leaves the count pointer alone.
            if (rd_en && !stat_held) begin
                if (rw_reg == RW_LSB_MSB) begin
                    rd_msb_reg <= ~rd_msb_reg;
                    if (rd_msb_reg)
                        latch_held_reg <= 1'b0;
                end else begin
                    latch_held_reg <= 1'b0;
                end
            end
        end
    end

    assign load       = load_reg;
    assign load_value = load_value_reg;
    assign cfg_strobe = cfg_strobe_reg;
    assign mode       = mode_reg;
    assign bcd        = bcd_reg;
    assign null_count = null_reg;

endmodule

// File: rtl/i8254_bus_sequencer.sv
// 8254 CPU-bus sequencer: pin synchronizers, strobe edge detection, address and
// control-word decode, read mux. Optional read-back command under I8254_READBACK_EN.
module i8254_bus_sequencer
    import i8254_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 a0,
    input  logic                 a1,
    input  logic [7:0]           d_in,
    output logic [7:0]           d_out,
    output logic                 d_oe,
    input  logic [3*COUNT_W-1:0] count_in,
    input  logic [2:0]           out_in,
    input  logic [2:0]           count_loaded,
    output logic [2:0]           load,
    output logic [COUNT_W-1:0]   load_value,
    output logic [2:0]           cfg_strobe,
    output logic [8:0]           mode_o,
    output logic [2:0]           bcd_o,
    output logic [2:0]           null_count
);

    localparam int PW = 13;
    localparam int CS_B = 12;
    localparam int RD_B = 11;
    localparam int WR_B = 10;
    localparam logic [PW-1:0] PINS_IDLE = {3'b111, 10'd0};

    // Address and data travel through the same stages as the strobes so they stay aligned.
    logic [PW-1:0] pins_raw;
    logic [PW-1:0] pins_s;
    logic [PW-1:0] pins_p_reg;
    assign pins_raw = {cs_n, rd_n, wr_n, a1, a0, d_in};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pins_s = pins_raw;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][PW-1:0] stage_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= {SYNC_STAGES{PINS_IDLE}};
                end else begin
                    stage_reg[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        stage_reg[i] <= stage_reg[i-1];
                end
            end
            assign pins_s = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic       wr_rise;
    logic       rd_rise;
    logic       wr_commit_reg;
    logic       rd_commit_reg;
    logic [1:0] addr_reg;
    logic [7:0] data_reg;

    assign wr_rise = pins_s[WR_B] & ~pins_p_reg[WR_B] & ~pins_p_reg[CS_B] & pins_p_reg[RD_B];
    assign rd_rise = pins_s[RD_B] & ~pins_p_reg[RD_B] & ~pins_p_reg[CS_B] & pins_p_reg[WR_B];

    always_ff @(posedge clk) begin
        if (reset) begin
            pins_p_reg    <= PINS_IDLE;
            wr_commit_reg <= 1'b0;
            rd_commit_reg <= 1'b0;
            addr_reg      <= 2'b00;
            data_reg      <= 8'h00;
        end else begin
            pins_p_reg    <= pins_s;
            wr_commit_reg <= wr_rise;
            rd_commit_reg <= rd_rise;
            if (wr_rise || rd_rise) begin
                addr_reg <= pins_p_reg[9:8];
                data_reg <= pins_p_reg[7:0];
            end
        end
    end

    logic ctrl_wr;
    logic rb_cmd;
    assign ctrl_wr = wr_commit_reg && (addr_reg == ADDR_CTRL);
`ifdef I8254_READBACK_EN
    assign rb_cmd = ctrl_wr && (data_reg[7:6] == SC_READBACK);
`else
    assign rb_cmd = 1'b0;
`endif

    logic [2:0]       cnt_wr;
    logic [2:0]       cnt_rd;
    logic [2:0]       cfg_en;
    logic [2:0]       latch_en;
    logic [2:0]       stat_en;
    logic [2:0][15:0] lv_w;
    logic [2:0][7:0]  rd_byte_w;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ctr
            assign cnt_wr[gi]   = wr_commit_reg && (addr_reg == 2'(gi));
            assign cnt_rd[gi]   = rd_commit_reg && (addr_reg == 2'(gi));
            assign cfg_en[gi]   = ctrl_wr && (data_reg[7:6] == 2'(gi)) && (data_reg[5:4] != RW_LATCH);
            assign latch_en[gi] = (ctrl_wr && (data_reg[7:6] == 2'(gi)) && (data_reg[5:4] == RW_LATCH))
                                || (rb_cmd && !data_reg[5] && data_reg[gi+1]);
            assign stat_en[gi]  = rb_cmd && !data_reg[4] && data_reg[gi+1];

            i8254_byte_ptr u_ptr (
                .clk          (clk),
                .reset        (reset),
                .wr_en        (cnt_wr[gi]),
                .rd_en        (cnt_rd[gi]),
                .cfg_en       (cfg_en[gi]),
                .latch_en     (latch_en[gi]),
                .stat_en      (stat_en[gi]),
                .d            (data_reg),
                .count        (count_in[COUNT_W*gi +: COUNT_W]),
                .out_pin      (out_in[gi]),
                .count_loaded (count_loaded[gi]),
                .load         (load[gi]),
                .load_value   (lv_w[gi]),
                .cfg_strobe   (cfg_strobe[gi]),
                .mode         (mode_o[3*gi +: 3]),
                .bcd          (bcd_o[gi]),
                .null_count   (null_count[gi]),
                .rd_byte      (rd_byte_w[gi])
            );
        end
    endgenerate

    always_comb begin
        load_value = '0;
        for (int i = 0; i < 3; i++)
            if (load[i])
                load_value = lv_w[i];
    end

    // Drive enable follows the raw pins so the CPU sees data within its read strobe.
    always_comb begin
        d_oe  = ~cs_n & ~rd_n & wr_n & ({a1, a0} != ADDR_CTRL);
        d_out = 8'h00;
        if (d_oe) begin
            case ({a1, a0})
                2'd0:    d_out = rd_byte_w[0];
                2'd1:    d_out = rd_byte_w[1];
                default: d_out = rd_byte_w[2];
            endcase
        end
    end

endmodule

// File: tb/tb_i8254_bus_sequencer.sv
// Directed self-checking bench for i8254_bus_sequencer; read-back checks switch on I8254_READBACK_EN.
module tb_i8254_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        a0 = 1'b0;
    logic        a1 = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [47:0] count_in = '0;
    logic [2:0]  out_in = '0;
    logic [2:0]  count_loaded = '0;
    logic [2:0]  load;
    logic [15:0] load_value;
    logic [2:0]  cfg_strobe;
    logic [8:0]  mode_o;
    logic [2:0]  bcd_o;
    logic [2:0]  null_count;

    int n_checks = 0;
    int n_fail = 0;

    int          ld_cyc, ld_cnt, cfg_cyc;
    logic [15:0] lv;
    logic [2:0]  ld_mask, cfg_mask;
    logic [7:0]  rv;
    logic        roe;

    always #5 clk = ~clk;

    i8254_bus_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .a0           (a0),
        .a1           (a1),
        .d_in         (d_in),
        .d_out        (d_out),
        .d_oe         (d_oe),
        .count_in     (count_in),
        .out_in       (out_in),
        .count_loaded (count_loaded),
        .load         (load),
        .load_value   (load_value),
        .cfg_strobe   (cfg_strobe),
        .mode_o       (mode_o),
        .bcd_o        (bcd_o),
        .null_count   (null_count)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("reset applied");
    endtask

    // Full CPU write; records when load/cfg_strobe fire, counted in cycles after wr_n rises.
    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        ld_cyc = -1; ld_cnt = 0; lv = '0; ld_mask = '0; cfg_cyc = -1; cfg_mask = '0;
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = a; d_in = d; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) cs_n = 1'b1;
            if (load != 3'b000) begin
                if (ld_cyc < 0) begin ld_cyc = c; lv = load_value; end
                ld_cnt++;
                ld_mask |= load;
            end
            if (cfg_strobe != 3'b000) begin
                if (cfg_cyc < 0) cfg_cyc = c;
                cfg_mask |= cfg_strobe;
            end
        end
        $display("write a=%0d d=%h load=%b@%0d lv=%h cfg=%b@%0d", a, d, ld_mask, ld_cyc, lv, cfg_mask, cfg_cyc);
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] val, output logic oe);
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = a; rd_n = 1'b0;
        @(negedge clk);
        val = d_out; oe = d_oe;
        repeat (2) @(negedge clk);
        rd_n = 1'b1;
        @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        $display("read  a=%0d d_out=%h d_oe=%b", a, val, oe);
    endtask

    task automatic pulse_loaded(input logic [2:0] m);
        @(negedge clk);
        count_loaded = m;
        @(negedge clk);
        count_loaded = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mode_o !== 9'd0) begin n_fail++; $display("FAIL reset_mode: got %h expected %h", mode_o, 9'd0); end
        n_checks++; if (bcd_o !== 3'b000) begin n_fail++; $display("FAIL reset_bcd: got %b expected %b", bcd_o, 3'b000); end
        n_checks++; if (d_oe !== 1'b0 || d_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %b/%h expected 0/00", d_oe, d_out); end
        n_checks++; if (load !== 3'b000 || cfg_strobe !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b/%b expected 000/000", load, cfg_strobe); end
        count_in[15:0] = 16'h1234;
        do_read(2'd0, rv, roe);
        n_checks++; if (rv !== 8'h34) begin n_fail++; $display("FAIL reset_read: got %h expected %h", rv, 8'h34); end
        n_checks++; if (roe !== 1'b1) begin n_fail++; $display("FAIL reset_read_oe: got %b expected 1", roe); end
        n_checks++; if (load !== 3'b000 || null_count !== 3'b000) begin n_fail++; $display("FAIL reset_read_side: got load=%b null=%b expected 000/000", load, null_count); end
    endtask

    task automatic test_lsb_msb();
        do_write(2'd3, 8'h34);
        n_checks++; if (cfg_mask !== 3'b001 || cfg_cyc !== 4) begin n_fail++; $display("FAIL cfg0_strobe: got %b@%0d expected 001@4", cfg_mask, cfg_cyc); end
        n_checks++; if (ld_mask !== 3'b000) begin n_fail++; $display("FAIL cfg0_noload: got %b expected 000", ld_mask); end
        n_checks++; if (mode_o[2:0] !== 3'd2) begin n_fail++; $display("FAIL cfg0_mode: got %0d expected 2", mode_o[2:0]); end
        n_checks++; if (null_count !== 3'b001) begin n_fail++; $display("FAIL cfg0_null: got %b expected 001", null_count); end
        do_write(2'd0, 8'hCD);
        n_checks++; if (ld_mask !== 3'b000) begin n_fail++; $display("FAIL lsb_staged: got load %b expected 000", ld_mask); end
        do_write(2'd0, 8'hAB);
        n_checks++; if (ld_mask !== 3'b001 || ld_cyc !== 4 || ld_cnt !== 1) begin n_fail++; $display("FAIL msb_load: got %b@%0d x%0d expected 001@4 x1", ld_mask, ld_cyc, ld_cnt); end
        n_checks++; if (lv !== 16'hABCD) begin n_fail++; $display("FAIL msb_value: got %h expected %h", lv, 16'hABCD); end
        n_checks++; if (null_count[0] !== 1'b1) begin n_fail++; $display("FAIL null_held: got %b expected 1", null_count[0]); end
        pulse_loaded(3'b001);
        n_checks++; if (null_count[0] !== 1'b0) begin n_fail++; $display("FAIL null_clear: got %b expected 0", null_count[0]); end
    endtask

    task automatic test_lsb_only();
        do_write(2'd3, 8'h50);
        n_checks++; if (cfg_mask !== 3'b010 || mode_o[5:3] !== 3'd0) begin n_fail++; $display("FAIL cfg1: got cfg=%b mode=%0d expected 010/0", cfg_mask, mode_o[5:3]); end
        do_write(2'd1, 8'h7F);
        n_checks++; if (ld_mask !== 3'b010 || ld_cyc !== 4) begin n_fail++; $display("FAIL lsb1_load: got %b@%0d expected 010@4", ld_mask, ld_cyc); end
        n_checks++; if (lv !== 16'h007F) begin n_fail++; $display("FAIL lsb1_value: got %h expected %h", lv, 16'h007F); end
        pulse_loaded(3'b010);
        n_checks++; if (null_count !== 3'b000) begin n_fail++; $display("FAIL null1_clear: got %b expected 000", null_count); end
    endtask

    task automatic test_latch();
        count_in[47:32] = 16'h5A5A;
        do_write(2'd3, 8'h80);
        n_checks++; if (cfg_mask !== 3'b000 || ld_mask !== 3'b000) begin n_fail++; $display("FAIL latch_cmd_side: got cfg=%b load=%b expected 000/000", cfg_mask, ld_mask); end
        count_in[47:32] = 16'h1111;
        do_write(2'd3, 8'h80);
        do_read(2'd2, rv, roe);
        n_checks++; if (rv !== 8'h5A) begin n_fail++; $display("FAIL latch_read: got %h expected %h", rv, 8'h5A); end
        do_read(2'd2, rv, roe);
        n_checks++; if (rv !== 8'h11) begin n_fail++; $display("FAIL latch_release: got %h expected %h", rv, 8'h11); end
    endtask

    task automatic test_illegal();
        do_read(2'd3, rv, roe);
        n_checks++; if (roe !== 1'b0 || rv !== 8'h00) begin n_fail++; $display("FAIL ctrl_read: got oe=%b d=%h expected 0/00", roe, rv); end
        ld_mask = '0; cfg_mask = '0;
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = 2'd1; d_in = 8'h99; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        roe = d_oe;
        repeat (2) @(negedge clk);
        rd_n = 1'b1; wr_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) cs_n = 1'b1;
            ld_mask |= load;
            cfg_mask |= cfg_strobe;
        end
        $display("illegal rd+wr a=1 d_oe=%b load=%b cfg=%b", roe, ld_mask, cfg_mask);
        n_checks++; if (roe !== 1'b0) begin n_fail++; $display("FAIL illegal_oe: got %b expected 0", roe); end
        n_checks++; if (ld_mask !== 3'b000 || cfg_mask !== 3'b000) begin n_fail++; $display("FAIL illegal_state: got load=%b cfg=%b expected 000/000", ld_mask, cfg_mask); end
    endtask

    task automatic test_mode_alias();
        do_write(2'd3, 8'h5E);
        n_checks++; if (mode_o[5:3] !== 3'd3) begin n_fail++; $display("FAIL mode_alias: got %0d expected 3", mode_o[5:3]); end
        pulse_loaded(3'b010);
    endtask

    task automatic test_reset_mid();
        do_write(2'd3, 8'h34);
        do_write(2'd0, 8'h55);
        ld_mask = '0;
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = 2'd0; d_in = 8'h66; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ld_mask |= load;
        end
        $display("reset mid-write load=%b null=%b", ld_mask, null_count);
        n_checks++; if (ld_mask !== 3'b000 || null_count !== 3'b000) begin n_fail++; $display("FAIL midreset_quiet: got load=%b null=%b expected 000/000", ld_mask, null_count); end
        do_write(2'd0, 8'h01);
        n_checks++; if (ld_mask !== 3'b001 || lv !== 16'h0001) begin n_fail++; $display("FAIL midreset_load: got %b lv=%h expected 001 lv=0001", ld_mask, lv); end
    endtask

    task automatic test_readback();
        do_write(2'd3, 8'h34);
        pulse_loaded(3'b001);
        out_in = 3'b001;
        count_in[15:0] = 16'hBEEF;
        do_write(2'd3, 8'hC2);
        n_checks++; if (cfg_mask !== 3'b000 || ld_mask !== 3'b000) begin n_fail++; $display("FAIL rb_side: got cfg=%b load=%b expected 000/000", cfg_mask, ld_mask); end
        n_checks++; if (mode_o[2:0] !== 3'd2 || null_count !== 3'b000) begin n_fail++; $display("FAIL rb_cfg_kept: got mode=%0d null=%b expected 2/000", mode_o[2:0], null_count); end
        count_in[15:0] = 16'h0000;
`ifdef I8254_READBACK_EN
        do_read(2'd0, rv, roe);
        n_checks++; if (rv !== 8'hB4) begin n_fail++; $display("FAIL rb_status: got %h expected %h", rv, 8'hB4); end
        do_read(2'd0, rv, roe);
        n_checks++; if (rv !== 8'hEF) begin n_fail++; $display("FAIL rb_lsb: got %h expected %h", rv, 8'hEF); end
        do_read(2'd0, rv, roe);
        n_checks++; if (rv !== 8'hBE) begin n_fail++; $display("FAIL rb_msb: got %h expected %h", rv, 8'hBE); end
`else
        do_read(2'd0, rv, roe);
        n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL rb_ignored: got %h expected %h", rv, 8'h00); end
`endif
    endtask

    initial begin
        test_reset();
        test_lsb_msb();
        test_lsb_only();
        test_latch();
        test_illegal();
        test_mode_alias();
        test_reset_mid();
        test_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
